// File: rtl/asym_fifo_pkg.sv
// Shared types and elaboration-time helpers for the asymmetric read-unpack FIFO.
// Used by asym_fifo_rd_unpack and asym_fifo_mem.
package asym_fifo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } fetch_state_t;

  function automatic bit ratio_legal(input int ratio);
    return (ratio == 2) || (ratio == 4);
  endfunction

  function automatic bit width_legal(input int wr_width, input int ratio);
    return (ratio > 0) && (wr_width > 0) && ((wr_width % ratio) == 0);
  endfunction

  function automatic int rd_width_of(input int wr_width, input int ratio);
    return wr_width / ratio;
  endfunction

  // Lane index width; a ratio of 2 still needs one bit.
  function automatic int lane_width(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/asym_fifo_mem.sv
// Single-clock simple-dual-port word store with registered read data.
// No reset on the array or the read register so it infers as block RAM.
module asym_fifo_mem
  import asym_fifo_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/asym_fifo_rd_unpack.sv
// Wide-write / narrow-read FIFO: stores WR_WIDTH words, emits RATIO sub-words each, lane 0 first.
// Optional sticky overflow output enabled by defining ASYM_FIFO_OVF_FLAG_EN.
module asym_fifo_rd_unpack
  import asym_fifo_pkg::*;
#(
  parameter int WR_WIDTH   = 32,
  parameter int RATIO      = 2,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                      clk,
  input  logic                      lreset_n,
  input  logic                      flush,
  input  logic                      wr_en,
  input  logic [WR_WIDTH-1:0]       wr_data,
  output logic                      full,
`ifdef ASYM_FIFO_OVF_FLAG_EN
  output logic                      overflow,
`endif
  output logic [ADDR_WIDTH:0]       wr_count,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [WR_WIDTH/RATIO-1:0] rd_data
);

  localparam int RD_WIDTH = rd_width_of(WR_WIDTH, RATIO);
  localparam int LANE_W   = lane_width(RATIO);
  localparam int DEPTH    = 2 ** ADDR_WIDTH;

  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(RATIO - 1);
  localparam logic [LANE_W-1:0]     LANE_ONE  = LANE_W'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  if (!ratio_legal(RATIO)) begin : g_bad_ratio
    $error("asym_fifo_rd_unpack: RATIO must be 2 or 4");
  end
  if (!width_legal(WR_WIDTH, RATIO)) begin : g_bad_width
    $error("asym_fifo_rd_unpack: WR_WIDTH must be divisible by RATIO");
  end

  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [WR_WIDTH-1:0]   r_cur;
  logic [WR_WIDTH-1:0]   r_nxt;
  logic                  r_cur_valid;
  logic                  r_nxt_valid;
  logic [LANE_W-1:0]     r_lane;
  fetch_state_t          r_state;
  fetch_state_t          w_state_next;

  logic                  w_wr_accept;
  logic                  w_beat;
  logic                  w_retire;
  logic                  w_land;
  logic                  w_cur_free;
  logic                  w_issue;
  logic [1:0]            w_occ_after;
  logic [WR_WIDTH-1:0]   w_mem_rdata;

  assign full        = (r_count == CNT_FULL);
  assign wr_count    = r_count;
  assign rd_valid    = r_cur_valid;
  assign w_wr_accept = wr_en && !full && !flush;
  assign w_beat      = r_cur_valid && rd_ready;
  assign w_retire    = w_beat && (r_lane == LAST_LANE);
  assign w_land      = (r_state == READ);
  assign w_cur_free  = !r_cur_valid || w_retire;

  asym_fifo_mem #(
    .WIDTH      (WR_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_accept),
    .i_wr_addr (r_wptr),
    .i_wr_data (wr_data),
    .i_rd_en   (w_issue),
    .i_rd_addr (r_rptr),
    .o_rd_data (w_mem_rdata)
  );

  // A new read is issued only if, after this edge, at most one of cur/nxt is
  // occupied, so the word landing next edge always has a slot.
  always_comb begin
    w_state_next = IDLE;
    w_issue      = 1'b0;
    w_occ_after  = 2'(r_cur_valid) + 2'(r_nxt_valid) + 2'(w_land) - 2'(w_retire);
    if (!flush && (r_count != '0) && (w_occ_after <= 2'd1)) begin
      w_issue = 1'b1;
    end
    if (w_issue) begin
      w_state_next = READ;
    end
  end

  always_ff @(posedge clk or negedge lreset_n) begin
    if (!lreset_n) begin
      r_state <= IDLE;
    end else if (flush) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge lreset_n) begin
    if (!lreset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_accept) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_issue) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_wr_accept, w_issue})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Landing data fills cur when cur is empty or retiring; nxt otherwise.
  always_ff @(posedge clk or negedge lreset_n) begin
    if (!lreset_n) begin
      r_cur       <= '0;
      r_nxt       <= '0;
      r_cur_valid <= 1'b0;
      r_nxt_valid <= 1'b0;
      r_lane      <= '0;
    end else if (flush) begin
      r_cur       <= '0;
      r_nxt       <= '0;
      r_cur_valid <= 1'b0;
      r_nxt_valid <= 1'b0;
      r_lane      <= '0;
    end else begin
      if (w_beat) begin
        r_lane <= w_retire ? '0 : r_lane + LANE_ONE;
      end
      if (w_cur_free) begin
        if (w_retire && r_nxt_valid) begin
          r_cur       <= r_nxt;
          r_cur_valid <= 1'b1;
          r_nxt_valid <= w_land;
          if (w_land) begin
            r_nxt <= w_mem_rdata;
          end
        end else if (w_land) begin
          r_cur       <= w_mem_rdata;
          r_cur_valid <= 1'b1;
        end else begin
          r_cur_valid <= 1'b0;
        end
      end else if (w_land) begin
        r_nxt       <= w_mem_rdata;
        r_nxt_valid <= 1'b1;
      end
    end
  end

  logic [RD_WIDTH-1:0] w_lanes [RATIO];

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign w_lanes[gi] = r_cur[gi*RD_WIDTH +: RD_WIDTH];
  end

  assign rd_data = w_lanes[r_lane];

`ifdef ASYM_FIFO_OVF_FLAG_EN
  logic r_overflow;

  always_ff @(posedge clk or negedge lreset_n) begin
    if (!lreset_n) begin
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_overflow <= 1'b0;
    end else if (wr_en && full) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
`endif

endmodule

// File: tb/tb_asym_fifo_rd_unpack.sv
// Directed self-checking bench for asym_fifo_rd_unpack (RATIO=2 default instance and a RATIO=4 instance).
// Overflow checks are compiled in when ASYM_FIFO_OVF_FLAG_EN is defined.
module tb_asym_fifo_rd_unpack;

  logic        clk = 1'b0;
  logic        lreset_n = 1'b0;
  logic        flush = 1'b0;

  logic        wr_en0 = 1'b0;
  logic [31:0] wr_data0 = '0;
  logic        rd_ready0 = 1'b0;
  logic        full0;
  logic [9:0]  wr_count0;
  logic        rd_valid0;
  logic [15:0] rd_data0;

  logic        wr_en4 = 1'b0;
  logic [31:0] wr_data4 = '0;
  logic        rd_ready4 = 1'b1;
  logic        full4;
  logic [4:0]  wr_count4;
  logic        rd_valid4;
  logic [7:0]  rd_data4;

`ifdef ASYM_FIFO_OVF_FLAG_EN
  logic        ovf0;
  logic        ovf4;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  asym_fifo_rd_unpack #(.WR_WIDTH(32), .RATIO(2), .ADDR_WIDTH(9)) dut0 (
    .clk      (clk),
    .lreset_n (lreset_n),
    .flush    (flush),
    .wr_en    (wr_en0),
    .wr_data  (wr_data0),
    .full     (full0),
`ifdef ASYM_FIFO_OVF_FLAG_EN
    .overflow (ovf0),
`endif
    .wr_count (wr_count0),
    .rd_valid (rd_valid0),
    .rd_ready (rd_ready0),
    .rd_data  (rd_data0)
  );

  asym_fifo_rd_unpack #(.WR_WIDTH(32), .RATIO(4), .ADDR_WIDTH(4)) dut4 (
    .clk      (clk),
    .lreset_n (lreset_n),
    .flush    (flush),
    .wr_en    (wr_en4),
    .wr_data  (wr_data4),
    .full     (full4),
`ifdef ASYM_FIFO_OVF_FLAG_EN
    .overflow (ovf4),
`endif
    .wr_count (wr_count4),
    .rd_valid (rd_valid4),
    .rd_ready (rd_ready4),
    .rd_data  (rd_data4)
  );

  typedef struct {
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_ready;
    logic        exp_valid;
    logic [15:0] exp_data;
    int          exp_count;
  } vec_t;

  vec_t vecs[19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  logic [15:0] q[$];
  logic [15:0] exp_sub;
  logic [31:0] w;
  logic [31:0] fw[5];
  int          k;
  int          words;
  logic        prev_stall;
  logic [15:0] prev_data;

  initial begin
    // single word, two back-to-back words, then a word read under backpressure
    vecs[0]  = '{1'b1, 32'hDDCCBBAA, 1'b1, 1'b0, 16'h0000, 1};
    vecs[1]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 16'h0000, 0};
    vecs[2]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 16'hBBAA, 0};
    vecs[3]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 16'hDDCC, 0};
    vecs[4]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 16'h0000, 0};
    vecs[5]  = '{1'b1, 32'h11112222, 1'b1, 1'b0, 16'h0000, 1};
    vecs[6]  = '{1'b1, 32'h33334444, 1'b1, 1'b0, 16'h0000, 1};
    vecs[7]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 16'h2222, 0};
    vecs[8]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 16'h1111, 0};
    vecs[9]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 16'h4444, 0};
    vecs[10] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 16'h3333, 0};
    vecs[11] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 16'h0000, 0};
    vecs[12] = '{1'b1, 32'hAAAA5555, 1'b0, 1'b0, 16'h0000, 1};
    vecs[13] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 16'h0000, 0};
    vecs[14] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 16'h5555, 0};
    vecs[15] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 16'h5555, 0};
    vecs[16] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 16'hAAAA, 0};
    vecs[17] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 16'hAAAA, 0};
    vecs[18] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 16'h0000, 0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(rd_valid0), 32'd0);
    chk("rst_count", 32'(wr_count0), 32'd0);
    chk("rst_full", 32'(full0), 32'd0);
    chk("rst_data", 32'(rd_data0), 32'd0);
    chk("rst_valid4", 32'(rd_valid4), 32'd0);
`ifdef ASYM_FIFO_OVF_FLAG_EN
    chk("rst_ovf", 32'(ovf0), 32'd0);
`endif
    lreset_n = 1'b1;
    tick();

    // table-driven vectors
    for (int i = 0; i < 19; i++) begin
      wr_en0    = vecs[i].wr_en;
      wr_data0  = vecs[i].wr_data;
      rd_ready0 = vecs[i].rd_ready;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(rd_valid0), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_count", i), 32'(wr_count0), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_full", i), 32'(full0), 32'd0);
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_data", i), 32'(rd_data0), 32'(vecs[i].exp_data));
      end
    end
    wr_en0 = 1'b0;

    // fill with consumer stalled: 2 words prefetched, 512 resident
    do_flush();
    rd_ready0 = 1'b0;
    for (int i = 0; i < 514; i++) begin
      wr_en0   = 1'b1;
      wr_data0 = {16'(2 * i + 1), 16'(2 * i)};
      tick();
      if (i == 512) begin
        chk("fill_count_511", 32'(wr_count0), 32'd511);
        chk("fill_notfull", 32'(full0), 32'd0);
      end
    end
    chk("fill_count_512", 32'(wr_count0), 32'd512);
    chk("fill_full", 32'(full0), 32'd1);
    wr_data0 = 32'hFFFF_FFFF;
    tick();
    wr_en0 = 1'b0;
    chk("drop_count", 32'(wr_count0), 32'd512);
    chk("drop_full", 32'(full0), 32'd1);
`ifdef ASYM_FIFO_OVF_FLAG_EN
    chk("ovf_set", 32'(ovf0), 32'd1);
`endif
    rd_ready0 = 1'b1;
    k = 0;
    for (int c = 0; c < 1200 && k < 1028; c++) begin
      if (rd_valid0) begin
        chk("drain_data", 32'(rd_data0), 32'(16'(k)));
        k++;
      end
      tick();
    end
    chk("drain_beats", 32'(k), 32'd1028);
    tick();
    chk("drain_valid", 32'(rd_valid0), 32'd0);
    chk("drain_count", 32'(wr_count0), 32'd0);
    chk("drain_full", 32'(full0), 32'd0);
`ifdef ASYM_FIFO_OVF_FLAG_EN
    chk("ovf_sticky", 32'(ovf0), 32'd1);
    do_flush();
    chk("ovf_flush", 32'(ovf0), 32'd0);
`endif

    // backpressure: ready toggles 1010, random words every 5th cycle
    do_flush();
    q.delete();
    words = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 6000; c++) begin
      if (words == 1000 && q.size() == 0) break;
      if (prev_stall) begin
        chk("bp_hold_valid", 32'(rd_valid0), 32'd1);
        chk("bp_hold_data", 32'(rd_data0), 32'(prev_data));
      end
      rd_ready0 = ((c % 2) == 0);
      wr_en0 = (words < 1000) && ((c % 5) == 0);
      if (wr_en0) begin
        w = $urandom;
        wr_data0 = w;
        q.push_back(w[15:0]);
        q.push_back(w[31:16]);
        words++;
      end
      if (rd_valid0 && rd_ready0) begin
        if (q.size() == 0) begin
          chk("bp_extra_beat", 32'(rd_data0), 32'hFFFF_FFFF);
        end else begin
          exp_sub = q.pop_front();
          chk("bp_data", 32'(rd_data0), 32'(exp_sub));
        end
      end
      prev_stall = rd_valid0 && !rd_ready0;
      prev_data  = rd_data0;
      tick();
    end
    wr_en0 = 1'b0;
    chk("bp_left", 32'(q.size()), 32'd0);

    // flush with 3 resident words and lane=1
    do_flush();
    rd_ready0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fw[i]    = {8'hA0 + 8'(i), 8'hA1, 8'hB0 + 8'(i), 8'hB1};
      wr_en0   = 1'b1;
      wr_data0 = fw[i];
      tick();
    end
    wr_en0 = 1'b0;
    chk("fl_pre_count", 32'(wr_count0), 32'd3);
    rd_ready0 = 1'b1;
    tick();
    chk("fl_pre_lane1", 32'(rd_data0), 32'(fw[0][31:16]));
    flush    = 1'b1;
    wr_en0   = 1'b1;
    wr_data0 = 32'hDEADBEEF;
    tick();
    flush  = 1'b0;
    wr_en0 = 1'b0;
    chk("fl_valid", 32'(rd_valid0), 32'd0);
    chk("fl_count", 32'(wr_count0), 32'd0);
    chk("fl_full", 32'(full0), 32'd0);
    repeat (3) begin
      tick();
      chk("fl_quiet", 32'(rd_valid0), 32'd0);
    end
    wr_en0   = 1'b1;
    wr_data0 = 32'h12345678;
    tick();
    wr_en0 = 1'b0;
    tick();
    tick();
    chk("fl_after_v0", 32'(rd_valid0), 32'd1);
    chk("fl_after_d0", 32'(rd_data0), 32'h5678);
    tick();
    chk("fl_after_d1", 32'(rd_data0), 32'h1234);
    tick();
    chk("fl_after_end", 32'(rd_valid0), 32'd0);

    // RATIO=4 continuous stream: valid after edge 2, then 32 beats without bubbles
    do_flush();
    rd_ready4 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      wr_en4   = (c < 8);
      wr_data4 = {8'(4 * c + 3), 8'(4 * c + 2), 8'(4 * c + 1), 8'(4 * c)};
      tick();
      if (c >= 2 && c <= 33) begin
        chk("r4_valid", 32'(rd_valid4), 32'd1);
        chk("r4_data", 32'(rd_data4), 32'(8'(c - 2)));
      end else begin
        chk("r4_idle", 32'(rd_valid4), 32'd0);
      end
    end
    wr_en4 = 1'b0;

    // asynchronous reset in the middle of a transfer
    do_flush();
    rd_ready0 = 1'b1;
    wr_en0    = 1'b1;
    wr_data0  = 32'hCAFEF00D;
    tick();
    wr_data0 = 32'h0BADBEEF;
    tick();
    wr_en0 = 1'b0;
    tick();
    tick();
    chk("mr_pre_data", 32'(rd_data0), 32'hCAFE);
    #2;
    lreset_n = 1'b0;
    #1;
    chk("mr_valid", 32'(rd_valid0), 32'd0);
    chk("mr_count", 32'(wr_count0), 32'd0);
    chk("mr_data", 32'(rd_data0), 32'd0);
    @(posedge clk);
    #3;
    lreset_n = 1'b1;
    repeat (4) begin
      tick();
      chk("mr_post_valid", 32'(rd_valid0), 32'd0);
      chk("mr_post_count", 32'(wr_count0), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/asym_fifo_rd_unpack.md
Name: asym_fifo_rd_unpack

Overview:
- Single-clock FIFO with a wide write port and a narrow read port.
- Write side accepts WR_WIDTH-bit words. Read side emits RATIO sub-words per stored word over a valid/ready handshake.
- Storage is a sync-read simple-dual-port array that maps onto one TDP36K half. Read-side prefetch logic hides the BRAM read latency.
- Sits between wide datapath producers (DSP/bus logic) and narrow consumers. It is the read/unpack counterpart to asymmetric-memory writers.

Parameters:
- WR_WIDTH, 32, write word width; must be divisible by RATIO.
- RATIO, 2, sub-words per write word; legal values 2 or 4.
- ADDR_WIDTH, 9, memory address bits; DEPTH = 2**ADDR_WIDTH wide words.
- RD_WIDTH (localparam) = WR_WIDTH/RATIO.

Ports:
- clk  in  1  rising-edge clock for all logic
- lreset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all contents and state
- wr_en  in  1  write request
- wr_data  in  WR_WIDTH  write word
- full  out  1  memory holds DEPTH words; writes ignored
- wr_count  out  ADDR_WIDTH+1  wide words resident in the memory array (excludes prefetch buffer)
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts rd_data
- rd_data  out  RD_WIDTH  current sub-word

Behaviour:
- Reset: clk, asynchronous active-low lreset_n. All of the following clear to 0:
  - pointers, wr_count, full, rd_valid, rd_data, lane index, buffer valids, FSM=IDLE.
- Write:
  - Accepted at an edge when wr_en && !full. Stores to mem[wptr]; wptr wraps modulo DEPTH.
  - wr_en while full is dropped with no state change.
- Unpack order: lane 0 = wr_data[RD_WIDTH-1:0] is emitted first (little-endian); lane RATIO-1 is emitted last.
- Buffering: two wide registers.
  - cur: drives rd_data = cur[lane*RD_WIDTH +: RD_WIDTH].
  - nxt: prefetch slot.
  - rd_valid = cur_valid.
- Handshake:
  - A beat transfers at an edge with rd_valid && rd_ready. lane then increments.
  - On lane==RATIO-1 a beat retires cur: lane returns to 0 and cur loads nxt (or cur_valid clears if nxt is empty).
  - rd_data/rd_valid hold stable while rd_valid && !rd_ready.
- Fetch FSM: states IDLE, READ (address issued, BRAM data lands next edge).
  - IDLE -> READ when memory is non-empty and a landing slot is guaranteed (nxt free, or cur retiring this edge). rptr increments and wr_count decrements at that edge.
  - READ -> IDLE or READ (back-to-back) at the landing edge: data goes to cur if cur is empty or retiring, otherwise to nxt.
- Latency: a word written at edge E into an empty FIFO gives rd_valid=1 after edge E+2.
- Throughput: sustained 1 sub-word/cycle with rd_ready held high.
- wr_count: +1 on accepted write, -1 on read issue. Both at once leaves it unchanged. full = (wr_count==DEPTH).
- Simultaneous write and read issue at the same address is impossible: reads are issued only from resident words.
- Flush: has priority over everything, effective at the next edge.
  - Clears pointers, count, buffers, lane and FSM.
  - Drops any write or beat in the same cycle. In-flight BRAM data is discarded.
- Reset asserted mid-transfer: immediate asynchronous clear; no partial beat is delivered after release.

Optional Feature:
- Macro ASYM_FIFO_OVF_FLAG_EN.
- Defined:
  - Adds output overflow (1 bit).
  - Set sticky at the edge where wr_en && full; cleared only by lreset_n or flush.
  - A write attempt in the flush cycle does not set it.
- Undefined: port and logic absent; dropped writes are silent.

Decomposition:
- Package asym_fifo_pkg holds:
  - FSM state enum (IDLE, READ).
  - Legality checks/localparam functions for RATIO and RD_WIDTH.
  - Lane index width function clog2(RATIO).
- Sub-module asym_fifo_mem: single-clock simple-dual-port array, one write port and one sync-read port, registered read data, no reset on the array. It maps to TDP36K inference.

Test Plan:
- Single word, defaults: write 0xDDCCBBAA at edge 0, rd_ready=1 -> rd_valid after edge 2; rd_data 0xBBAA then 0xDDCC; rd_valid low after.
- Fill: 512 writes with rd_ready=0 -> full=1 and wr_count=512 after the 512th memory write (first 2 words prefetched, so 514 accepted). Extra write is dropped. Drain yields 1028 sub-words in order.
- Backpressure: stream with rd_ready toggling 1010 -> rd_data stable while stalled; no lane skipped or duplicated. Compare against a scoreboard over 1000 random words.
- Continuous stream, rd_ready=1, RATIO=4, WR_WIDTH=32 -> one 8-bit beat every cycle, no bubbles after initial latency.
- Flush with 3 words resident and lane=1 -> next cycle rd_valid=0, wr_count=0. A following write of 0x12345678 yields 0x5678, 0x1234.
- ASYM_FIFO_OVF_FLAG_EN: write while full -> overflow=1 and sticky through drain; flush -> 0.
